// File: rtl/boreal_vec_engine_v2.sv
// boreal_vec_engine_v2: MMIO-controlled INT8 SIMD engine (per-lane DOT accumulate or EWMUL) mastering SRAM.
// Optional build macro BOREAL_VEC_SAT_EN: saturate int8 results to [-128,127] instead of wrapping.
module boreal_vec_engine_v2 #(
    parameter int NUM_LANES = 4,
    parameter int ACC_W     = 32,
    parameter int DW        = 8*NUM_LANES
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sel,
    input  logic          wr,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          ack,
    output logic          sram_rd_req,
    output logic [31:0]   sram_rd_addr,
    input  logic [DW-1:0] sram_rd_data,
    input  logic          sram_rd_ack,
    output logic          sram_wr_req,
    output logic [31:0]   sram_wr_addr,
    output logic [DW-1:0] sram_wr_data,
    input  logic          sram_wr_ack,
    output logic          irq
);
    localparam int LG = $clog2(NUM_LANES);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_RD_A, S_RD_B, S_MAC, S_SCALE, S_WR, S_DONE
    } state_t;

    state_t r_state, w_state_next;

    logic                r_mode;
    logic [31:0]         r_src_a, r_src_b, r_dst, r_len, r_idx;
    logic signed [15:0]  r_mult;
    logic [4:0]          r_shift;
    logic [7:0]          r_zero;
    logic                r_busy, r_done, r_error, r_irq_en, r_abort_pend, r_fail;
    logic                r_rd_req, r_wr_req;
    logic [31:0]         r_rd_addr, r_wr_addr;
    logic [DW-1:0]       r_a_word, r_b_word, r_wr_data;
    logic [DW-1:0]       w_q;

    logic [7:0]  w_off;
    logic        w_mmio_wr, w_cfg_we, w_cmd_wr, w_misaligned;
    logic [31:0] w_idx_inc;
    logic        w_go, w_fail, w_cap_a, w_cap_b, w_mac, w_scale;
    logic        w_rd_issue, w_wr_issue, w_wr_done;

    assign w_off        = addr[7:0];
    assign w_mmio_wr    = sel && wr;
    assign w_cfg_we     = w_mmio_wr && !r_busy;
    assign w_cmd_wr     = w_mmio_wr && (w_off == 8'h00);
    assign w_idx_inc    = r_idx + 32'd1;
    assign w_misaligned = (r_src_a[LG-1:0] != '0) || (r_src_b[LG-1:0] != '0) ||
                          (r_dst[LG-1:0] != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // An abort with no request in flight ends the job at once; otherwise the ack is awaited first.
    always_comb begin
        w_state_next = r_state;
        w_go       = 1'b0;
        w_fail     = 1'b0;
        w_cap_a    = 1'b0;
        w_cap_b    = 1'b0;
        w_mac      = 1'b0;
        w_scale    = 1'b0;
        w_rd_issue = 1'b0;
        w_wr_issue = 1'b0;
        w_wr_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_wr && wdata[0]) begin
                    w_go         = 1'b1;
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_abort_pend || (r_len == '0) || w_misaligned) w_fail = 1'b1;
                else                                               w_state_next = S_RD_A;
            end
            S_RD_A, S_RD_B: begin
                if (r_rd_req) begin
                    if (sram_rd_ack) begin
                        if (r_abort_pend) begin
                            w_fail = 1'b1;
                        end else if (r_state == S_RD_A) begin
                            w_cap_a      = 1'b1;
                            w_state_next = S_RD_B;
                        end else begin
                            w_cap_b      = 1'b1;
                            w_state_next = S_MAC;
                        end
                    end
                end else if (r_abort_pend) begin
                    w_fail = 1'b1;
                end else begin
                    w_rd_issue = 1'b1;
                end
            end
            S_MAC: begin
                if (r_abort_pend) begin
                    w_fail = 1'b1;
                end else begin
                    w_mac        = 1'b1;
                    w_state_next = (!r_mode && (w_idx_inc < r_len)) ? S_RD_A : S_SCALE;
                end
            end
            S_SCALE: begin
                if (r_abort_pend) begin
                    w_fail = 1'b1;
                end else begin
                    w_scale      = 1'b1;
                    w_state_next = S_WR;
                end
            end
            S_WR: begin
                if (r_wr_req) begin
                    if (sram_wr_ack) begin
                        if (r_abort_pend) begin
                            w_fail = 1'b1;
                        end else begin
                            w_wr_done    = 1'b1;
                            w_state_next = (r_mode && (r_idx < r_len)) ? S_RD_A : S_DONE;
                        end
                    end
                end else if (r_abort_pend) begin
                    w_fail = 1'b1;
                end else begin
                    w_wr_issue = 1'b1;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (w_fail) w_state_next = S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode       <= 1'b0;
            r_src_a      <= '0;
            r_src_b      <= '0;
            r_dst        <= '0;
            r_len        <= '0;
            r_mult       <= '0;
            r_shift      <= '0;
            r_zero       <= '0;
            r_irq_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_abort_pend <= 1'b0;
            r_fail       <= 1'b0;
            r_idx        <= '0;
            r_rd_req     <= 1'b0;
            r_rd_addr    <= '0;
            r_wr_req     <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_a_word     <= '0;
            r_b_word     <= '0;
        end else begin
            if (w_cfg_we) begin
                case (w_off)
                    8'h04: r_src_a <= wdata;
                    8'h08: r_src_b <= wdata;
                    8'h0C: r_dst   <= wdata;
                    8'h10: r_len   <= wdata;
                    8'h14: begin
                        r_mult  <= wdata[15:0];
                        r_shift <= wdata[20:16];
                    end
                    8'h18: r_zero  <= wdata[7:0];
                    default: ;
                endcase
            end
            if (w_cmd_wr && !r_busy) r_mode <= wdata[2];
            if (w_mmio_wr && (w_off == 8'h20)) r_irq_en <= wdata[0];
            if (w_mmio_wr && (w_off == 8'h1C)) begin
                if (wdata[1]) r_done  <= 1'b0;
                if (wdata[2]) r_error <= 1'b0;
            end
            if (w_cmd_wr && wdata[1] && r_busy) r_abort_pend <= 1'b1;

            if (w_go) begin
                r_busy       <= 1'b1;
                r_done       <= 1'b0;
                r_error      <= 1'b0;
                r_idx        <= '0;
                r_abort_pend <= 1'b0;
                r_fail       <= 1'b0;
            end
            if (w_fail) begin
                r_error <= 1'b1;
                r_fail  <= 1'b1;
            end
            if (r_state == S_DONE) begin
                r_busy       <= 1'b0;
                r_done       <= !r_fail;
                r_abort_pend <= 1'b0;
            end
            if (w_mac) r_idx <= w_idx_inc;

            if (w_rd_issue) begin
                r_rd_req  <= 1'b1;
                r_rd_addr <= ((r_state == S_RD_A) ? r_src_a : r_src_b) + (r_idx << LG);
            end else if (r_rd_req && sram_rd_ack) begin
                r_rd_req <= 1'b0;
            end
            if (w_cap_a) r_a_word <= sram_rd_data;
            if (w_cap_b) r_b_word <= sram_rd_data;

            // EWMUL has already advanced idx in MAC, so the word just produced sits at idx-1.
            if (w_wr_issue) begin
                r_wr_req  <= 1'b1;
                r_wr_addr <= r_mode ? (r_dst + ((r_idx - 32'd1) << LG)) : r_dst;
            end else if (r_wr_req && sram_wr_ack) begin
                r_wr_req <= 1'b0;
            end
            if (w_scale) r_wr_data <= w_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic signed [7:0]        w_a, w_b;
            logic signed [15:0]       w_p;
            logic signed [ACC_W-1:0]  r_acc;
            logic signed [ACC_W+15:0] w_acc_x, w_mult_x, w_prod;

            assign w_a = r_a_word[8*gi +: 8];
            assign w_b = r_b_word[8*gi +: 8];
            assign w_p = $signed({{8{w_a[7]}}, w_a}) * $signed({{8{w_b[7]}}, w_b});

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                        r_acc <= '0;
                else if (w_go || (w_wr_done && r_mode)) r_acc <= '0;
                else if (w_mac)                    r_acc <= r_acc + {{(ACC_W-16){w_p[15]}}, w_p};
            end

            assign w_acc_x  = {{16{r_acc[ACC_W-1]}}, r_acc};
            assign w_mult_x = {{ACC_W{r_mult[15]}}, r_mult};
            assign w_prod   = w_acc_x * w_mult_x;

`ifdef BOREAL_VEC_SAT_EN
            logic signed [ACC_W+15:0] w_shr, w_sum;
            logic [ACC_W+8:0]         w_hi;
            assign w_shr = w_prod >>> r_shift;
            assign w_sum = w_shr + {{(ACC_W+8){r_zero[7]}}, r_zero};
            assign w_hi  = w_sum[ACC_W+15:7];
            // In range iff every bit above bit 7 matches the sign.
            assign w_q[8*gi +: 8] = ((w_hi == '0) || (w_hi == '1)) ? w_sum[7:0] :
                                    (w_sum[ACC_W+15] ? 8'h80 : 8'h7F);
`else
            assign w_q[8*gi +: 8] = 8'(w_prod >>> r_shift) + r_zero;
`endif
        end
    endgenerate

    always_comb begin
        rdata = '0;
        if (sel && !wr) begin
            case (w_off)
                8'h00:   rdata = {29'd0, r_mode, 2'b00};
                8'h04:   rdata = r_src_a;
                8'h08:   rdata = r_src_b;
                8'h0C:   rdata = r_dst;
                8'h10:   rdata = r_len;
                8'h14:   rdata = {11'd0, r_shift, r_mult};
                8'h18:   rdata = {24'd0, r_zero};
                8'h1C:   rdata = {29'd0, r_error, r_done, r_busy};
                8'h20:   rdata = {31'd0, r_irq_en};
                8'h24:   rdata = 32'(NUM_LANES);
                default: rdata = '0;
            endcase
        end
    end

    assign ack          = sel;
    assign irq          = r_irq_en & (r_done | r_error);
    assign sram_rd_req  = r_rd_req;
    assign sram_rd_addr = r_rd_addr;
    assign sram_wr_req  = r_wr_req;
    assign sram_wr_addr = r_wr_addr;
    assign sram_wr_data = r_wr_data;

endmodule

// File: tb/tb_boreal_vec_engine_v2.sv
// Self-checking bench for boreal_vec_engine_v2: vector table plus abort, error and busy-write sequences.
// Expected results follow BOREAL_VEC_SAT_EN when the bench is built with it.
module tb_boreal_vec_engine_v2;
`ifdef BOREAL_VEC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        ack;
    logic        sram_rd_req, sram_wr_req;
    logic [31:0] sram_rd_addr, sram_wr_addr;
    logic [31:0] sram_rd_data = '0, sram_wr_data;
    logic        sram_rd_ack = 1'b0, sram_wr_ack = 1'b0;
    logic        irq;

    always #5 clk = ~clk;

    boreal_vec_engine_v2 #(.NUM_LANES(4), .ACC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack),
        .sram_rd_req(sram_rd_req), .sram_rd_addr(sram_rd_addr),
        .sram_rd_data(sram_rd_data), .sram_rd_ack(sram_rd_ack),
        .sram_wr_req(sram_wr_req), .sram_wr_addr(sram_wr_addr),
        .sram_wr_data(sram_wr_data), .sram_wr_ack(sram_wr_ack),
        .irq(irq)
    );

    typedef struct {
        logic        mode;
        logic [31:0] len, a0, a1, b0, b1, scale;
        logic [7:0]  zero;
        logic [31:0] e0, e1;
    } vec_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_exp_t;

    vec_t        vecs [6];
    string       names [6];
    wr_exp_t     exp_q [$];
    logic [31:0] mem [64];
    int checks = 0, errors = 0;
    int rd_lat = 0, rd_wait = 0, n_rd = 0, n_req_cyc = 0, n_overlap = 0;
    logic last_ack = 1'b0;

    // SRAM model: acks on the falling edge after rd_lat stalled cycles; writes checked against the scoreboard.
    initial begin
        wr_exp_t e;
        forever begin
            @(negedge clk);
            sram_rd_ack = 1'b0;
            sram_wr_ack = 1'b0;
            if (sram_rd_req || sram_wr_req) n_req_cyc++;
            if (sram_rd_req && sram_wr_req) n_overlap++;
            if (sram_rd_req) begin
                if (rd_wait >= rd_lat) begin
                    sram_rd_ack  = 1'b1;
                    sram_rd_data = mem[sram_rd_addr[7:2]];
                    rd_wait = 0;
                    n_rd++;
                end else begin
                    rd_wait++;
                end
            end
            if (sram_wr_req) begin
                sram_wr_ack = 1'b1;
                mem[sram_wr_addr[7:2]] = sram_wr_data;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sram_write unexpected addr=%h data=%h required no write", sram_wr_addr, sram_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (sram_wr_addr !== e.addr || sram_wr_data !== e.data) begin
                        errors++;
                        $display("FAIL sram_write actual %h@%h required %h@%h", sram_wr_data, sram_wr_addr, e.data, e.addr);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic mmio_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; wr = 1'b1; addr = {24'd0, a}; wdata = d;
        @(negedge clk);
        sel = 1'b0; wr = 1'b0;
    endtask

    task automatic mmio_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; wr = 1'b0; addr = {24'd0, a};
        #1;
        d = rdata;
        last_ack = ack;
        sel = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] s;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            mmio_read(8'h1C, s);
            if (!s[0]) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout actual=busy after 400 polls required=idle", name);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name, input bit poke);
        logic [31:0] s;
        mem[6'h10] = v.a0; mem[6'h11] = v.a1;
        mem[6'h12] = 32'h11111111;
        mem[6'h20] = v.b0; mem[6'h21] = v.b1;
        mem[6'h30] = 32'hDEADBEEF; mem[6'h31] = 32'hDEADBEEF;
        exp_q.push_back('{32'h000000C0, v.e0});
        if (v.mode && v.len > 1) exp_q.push_back('{32'h000000C4, v.e1});
        mmio_write(8'h04, 32'h40);
        mmio_write(8'h08, 32'h80);
        mmio_write(8'h0C, 32'hC0);
        mmio_write(8'h10, v.len);
        mmio_write(8'h14, v.scale);
        mmio_write(8'h18, {24'd0, v.zero});
        mmio_write(8'h00, {29'd0, v.mode, 2'b01});
        if (poke) begin
            mmio_write(8'h04, 32'h48);
            mmio_write(8'h10, 32'd1);
            mmio_write(8'h00, {29'd0, ~v.mode, 2'b01});
        end
        wait_idle(name);
        mmio_read(8'h1C, s);
        chk({name, "_status"}, s, 32'h2);
        chk({name, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
        $display("vec %s mode=%0d len=%0d dst0=%h status=%h", name, v.mode, v.len, mem[6'h30], s);
    endtask

    initial begin
        logic [31:0] s;
        int n0, r0;
        bit seen;

        vecs[0] = '{1'b0, 32'd2, 32'h04030201, 32'h04030201, 32'h02020202, 32'h02020202,
                    32'h00000001, 8'h00, 32'h100C0804, 32'h0};
        vecs[1] = '{1'b1, 32'd1, 32'h04FD02FF, 32'h0, 32'h03030303, 32'h0,
                    32'h00010001, 8'h00, 32'h06FB03FE, 32'h0};
        vecs[2] = '{1'b0, 32'd1, 32'h7F7F7F7F, 32'h0, 32'h7F7F7F7F, 32'h0,
                    32'h00000001, 8'h00, SAT ? 32'h7F7F7F7F : 32'h01010101, 32'h0};
        vecs[3] = '{1'b1, 32'd2, 32'h01020304, 32'hFFFEFDFC, 32'h01010101, 32'h02020202,
                    32'h00000002, 8'h05, 32'h07090B0D, 32'h01FDF9F5};
        vecs[4] = '{1'b0, 32'd2, 32'h10101010, 32'h10101010, 32'h10101010, 32'h10101010,
                    32'h0004FFFF, 8'h00, 32'hE0E0E0E0, 32'h0};
        vecs[5] = '{1'b1, 32'd1, 32'h80808080, 32'h0, 32'h01010101, 32'h0,
                    32'h00000001, 8'hFF, SAT ? 32'h80808080 : 32'h7F7F7F7F, 32'h0};
        names = '{"dot_len2", "ewmul_shift", "dot_sat", "ewmul_len2_zp", "dot_neg_mult", "ewmul_low_sat"};
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        mmio_read(8'h1C, s); chk("reset_status", s, 32'h0);
        chk("reset_ack", {31'd0, last_ack}, 32'h1);
        mmio_read(8'h24, s); chk("lanes", s, 32'd4);
        mmio_read(8'h00, s); chk("reset_cmd", s, 32'h0);
        chk("reset_irq", {31'd0, irq}, 32'h0);
        chk("reset_reqs", {30'd0, sram_rd_req, sram_wr_req}, 32'h0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], names[i], 1'b0);

        // Zero length with IRQ enabled, then a misaligned pointer with IRQ disabled.
        n0 = n_req_cyc;
        mmio_write(8'h20, 32'h1);
        mmio_write(8'h10, 32'd0);
        mmio_write(8'h00, 32'h1);
        wait_idle("err_len0");
        mmio_read(8'h1C, s); chk("err_len0_status", s, 32'h4);
        chk("err_len0_irq", {31'd0, irq}, 32'h1);
        chk("err_len0_reqs", 32'(n_req_cyc - n0), 32'd0);
        mmio_write(8'h1C, 32'h6);
        mmio_read(8'h1C, s); chk("w1c_status", s, 32'h0);
        chk("w1c_irq", {31'd0, irq}, 32'h0);
        $display("err len0 status cleared irq=%0d", irq);

        n0 = n_req_cyc;
        mmio_write(8'h20, 32'h0);
        mmio_write(8'h10, 32'd1);
        mmio_write(8'h04, 32'h1002);
        mmio_write(8'h00, 32'h1);
        wait_idle("err_align");
        mmio_read(8'h1C, s); chk("err_align_status", s, 32'h4);
        chk("err_align_irq", {31'd0, irq}, 32'h0);
        chk("err_align_reqs", 32'(n_req_cyc - n0), 32'd0);
        mmio_write(8'h1C, 32'h6);
        $display("err align status=%h", s);

        // Abort while the first read is stalled.
        rd_lat = 5;
        r0 = n_rd;
        mmio_write(8'h04, 32'h40);
        mmio_write(8'h10, 32'd8);
        mmio_write(8'h00, 32'h5);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (sram_rd_req) begin seen = 1'b1; break; end
        end
        chk("abort_rd_req_seen", {31'd0, seen}, 32'h1);
        mmio_write(8'h00, 32'h2);
        wait_idle("abort");
        mmio_read(8'h1C, s); chk("abort_status", s, 32'h4);
        chk("abort_reads", 32'(n_rd - r0), 32'd1);
        n0 = n_req_cyc;
        repeat (5) @(negedge clk);
        chk("abort_no_more_reqs", 32'(n_req_cyc - n0), 32'd0);
        $display("abort reads=%0d status=%h", n_rd - r0, s);
        rd_lat = 0;
        mmio_write(8'h1C, 32'h6);
        run_vec(vecs[3], "after_abort", 1'b0);

        // Start, SRC_A and LEN rewritten while busy must not disturb the running job.
        rd_lat = 3;
        run_vec(vecs[3], "busy_poke", 1'b1);
        mmio_read(8'h04, s); chk("busy_poke_src_a", s, 32'h40);
        mmio_read(8'h10, s); chk("busy_poke_len", s, 32'd2);
        rd_lat = 0;

        chk("req_overlap", 32'(n_overlap), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
